// File: rtl/ram_w32x8192_sdp.sv
// Simple dual-port block RAM: one write port (A), one registered read port (B), single clock.
// Read-first on same-address collision; only the output register is reset, never the array.
module ram_w32x8192_sdp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13,
    parameter int DEPTH      = 8192
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic                  enb,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] doutb
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] doutb_q;
    logic [DATA_WIDTH-1:0] doutb_d;
    logic                  we;

    // Writes are suppressed while reset is held so a reset cycle cannot corrupt stored data.
    assign we = rst_n & ena & wea;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addra] <= dina;
        end
    end

    // Nonblocking write above plus this read of the pre-edge array gives read-first behaviour.
    always_comb begin
        doutb_d = doutb_q;
        if (enb) begin
            doutb_d = mem[addrb];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            doutb_q <= '0;
        end else begin
            doutb_q <= doutb_d;
        end
    end

    assign doutb = doutb_q;

endmodule

// File: tb/tb_ram_w32x8192_sdp.sv
// Directed table-driven bench for ram_w32x8192_sdp plus a streaming write/read sequence.
module tb_ram_w32x8192_sdp;

    localparam int DW = 32;
    localparam int AW = 13;

    logic          clk;
    logic          rst_n;
    logic          ena;
    logic          wea;
    logic [AW-1:0] addra;
    logic [DW-1:0] dina;
    logic          enb;
    logic [AW-1:0] addrb;
    logic [DW-1:0] doutb;

    int n_cmp = 0;
    int n_err = 0;

    ram_w32x8192_sdp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(8192)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .enb   (enb),
        .addrb (addrb),
        .doutb (doutb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          rst_n;
        logic          ena;
        logic          wea;
        logic [AW-1:0] addra;
        logic [DW-1:0] dina;
        logic          enb;
        logic [AW-1:0] addrb;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic r, logic ea, logic we, logic [AW-1:0] aa,
                                logic [DW-1:0] da, logic eb, logic [AW-1:0] ab, logic [DW-1:0] exp);
        vec_t v;
        v.name = name; v.rst_n = r; v.ena = ea; v.wea = we; v.addra = aa;
        v.dina = da; v.enb = eb; v.addrb = ab; v.exp = exp;
        return v;
    endfunction

    task automatic check(string name, logic [DW-1:0] exp);
        n_cmp++;
        if (doutb !== exp) begin
            n_err++;
            $display("FAIL %s: doutb=%08h expected %08h", name, doutb, exp);
        end
    endtask

    // Drive one cycle's inputs, clock once, sample 1 time unit after the edge.
    task automatic step(logic r, logic ea, logic we, logic [AW-1:0] aa, logic [DW-1:0] da,
                        logic eb, logic [AW-1:0] ab);
        rst_n = r; ena = ea; wea = we; addra = aa; dina = da; enb = eb; addrb = ab;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; wea = 1'b0; addra = '0; dina = '0; enb = 1'b0; addrb = '0;

        //              name            rst ena wea addra     dina          enb addrb     expected doutb
        vecs.push_back(mk("reset_state",  0, 0, 0, 13'h0000, 32'h0,        0, 13'h0000, 32'h0));
        vecs.push_back(mk("zero_a3",      1, 1, 1, 13'h0003, 32'h0,        0, 13'h0000, 32'h0));
        vecs.push_back(mk("zero_a10",     1, 1, 1, 13'h000A, 32'h0,        0, 13'h0000, 32'h0));
        vecs.push_back(mk("prefill_a5",   1, 1, 1, 13'h0005, 32'hDEADBEEF, 0, 13'h0000, 32'h0));
        vecs.push_back(mk("read_a5",      1, 0, 1, 13'h0000, 32'h0,        1, 13'h0005, 32'hDEADBEEF));
        vecs.push_back(mk("rst_cyc1",     0, 0, 0, 13'h0000, 32'h0,        1, 13'h0005, 32'h0));
        vecs.push_back(mk("rst_cyc2_wr",  0, 1, 1, 13'h0003, 32'hA5A5A5A5, 1, 13'h0005, 32'h0));
        vecs.push_back(mk("post_rst_a5",  1, 0, 0, 13'h0000, 32'h0,        1, 13'h0005, 32'hDEADBEEF));
        vecs.push_back(mk("rst_wr_drop",  1, 0, 0, 13'h0000, 32'h0,        1, 13'h0003, 32'h0));
        vecs.push_back(mk("wr_lo",        1, 1, 1, 13'h0000, 32'h12345678, 0, 13'h0000, 32'h0));
        vecs.push_back(mk("wr_hi",        1, 1, 1, 13'h1FFF, 32'hCAFEF00D, 0, 13'h0000, 32'h0));
        vecs.push_back(mk("rd_lo",        1, 0, 0, 13'h0000, 32'h0,        1, 13'h0000, 32'h12345678));
        vecs.push_back(mk("rd_hi",        1, 0, 0, 13'h0000, 32'h0,        1, 13'h1FFF, 32'hCAFEF00D));
        vecs.push_back(mk("wea0_hold",    1, 1, 0, 13'h000A, 32'hFFFFFFFF, 0, 13'h0000, 32'hCAFEF00D));
        vecs.push_back(mk("ena0_hold",    1, 0, 1, 13'h000A, 32'hFFFFFFFF, 0, 13'h0000, 32'hCAFEF00D));
        vecs.push_back(mk("rd_a10",       1, 0, 0, 13'h0000, 32'h0,        1, 13'h000A, 32'h0));
        vecs.push_back(mk("wr_a7",        1, 1, 1, 13'h0007, 32'h11111111, 0, 13'h0000, 32'h0));
        vecs.push_back(mk("collide_a7",   1, 1, 1, 13'h0007, 32'h22222222, 1, 13'h0007, 32'h11111111));
        vecs.push_back(mk("after_coll",   1, 0, 0, 13'h0000, 32'h0,        1, 13'h0007, 32'h22222222));
        vecs.push_back(mk("indep_ports",  1, 1, 1, 13'h0AAA, 32'h5555AAAA, 1, 13'h1FFF, 32'hCAFEF00D));
        vecs.push_back(mk("wr_lat_n1",    1, 0, 0, 13'h0000, 32'h0,        1, 13'h0AAA, 32'h5555AAAA));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].ena, vecs[i].wea, vecs[i].addra, vecs[i].dina,
                 vecs[i].enb, vecs[i].addrb);
            // Rows that only set up state before any read carry expected 0 and still compare.
            check(vecs[i].name, vecs[i].exp);
        end

        // Streaming: write a while reading a-1; each read returns the previous cycle's write.
        for (int a = 0; a < 256; a++) begin
            logic [AW-1:0] ra;
            ra = (a == 0) ? 13'h0 : 13'(a - 1);
            step(1'b1, 1'b1, 1'b1, 13'(a), 32'(a) * 32'h01010101, (a != 0), ra);
            if (a != 0) check($sformatf("stream_%0d", a - 1), 32'(a - 1) * 32'h01010101);
        end
        step(1'b1, 1'b0, 1'b0, 13'h0, 32'h0, 1'b1, 13'h00FF);
        check("stream_255", 32'hFFFFFFFF);

        // Hold after stream: enb low keeps the last value for several cycles.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 1'b1, 13'h00FF, 32'h0BADF00D, 1'b0, 13'h0000);
            check("hold_enb0", 32'hFFFFFFFF);
        end
        step(1'b1, 1'b0, 1'b0, 13'h0, 32'h0, 1'b1, 13'h00FF);
        check("rd_over_ff", 32'h0BADF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
